error_accum_ram: RTL and testbench

ERROR_ACCUM_RAM -- requirements
Module: error_accum_ram

---
 rtl/error_accum_ram.sv | 139 +++++++++++++
 tb/tb_error_accum_ram.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/error_accum_ram.sv
// Shared RAM with a host port and a per-cell error engine that accumulates
// (target - forward) into an accumulator region, saturating to the word range.
module error_accum_ram #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned NUM_CELL   = 10,
  parameter int unsigned FWD_BASE   = 0,
  parameter int unsigned ACC_BASE   = NUM_CELL,
  parameter int          TARGET_ONE = 1536
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] q,
  input  logic              start,
  input  logic [7:0]        label,
  input  logic              clear_acc,
  output logic              busy,
  output logic              done,
  output logic              sat
);

  typedef enum logic [2:0] {StIdle, StRdFwd, StRdAcc, StWrAcc, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [7:0]        label_q;
  logic              clear_q;
  logic              sat_q;
  logic [DATA_W-1:0] fwd_q;
  logic [DATA_W-1:0] eng_rd_q;
  logic [DATA_W-1:0] q_q;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic [ADDR_W-1:0] fwd_addr;
  logic [ADDR_W-1:0] acc_addr;
  logic [ADDR_W-1:0] eng_addr;
  logic              eng_we;
  logic              hit;
  logic [DATA_W:0]   target;
  logic [DATA_W:0]   err;
  logic [DATA_W+1:0] base;
  logic [DATA_W+1:0] sum;
  logic              ovf;
  logic [DATA_W-1:0] result;

  always_comb begin
    fwd_addr = ADDR_W'(FWD_BASE) + idx_q;
    acc_addr = ADDR_W'(ACC_BASE) + idx_q;
    eng_addr = (state_q == StRdAcc) ? acc_addr : fwd_addr;
    eng_we   = (state_q == StWrAcc);
    busy     = (state_q == StRdFwd) || (state_q == StRdAcc) || (state_q == StWrAcc);
    done     = (state_q == StDone);
    sat      = sat_q;
    q        = q_q;
  end

  // Error and saturating accumulate; eng_rd_q holds the acc word during StWrAcc.
  always_comb begin
    hit    = (32'(label_q) < NUM_CELL) && (32'(idx_q) == 32'(label_q));
    target = hit ? (DATA_W+1)'(TARGET_ONE) : '0;
    err    = target - {fwd_q[DATA_W-1], fwd_q};
    base   = clear_q ? '0 : {{2{eng_rd_q[DATA_W-1]}}, eng_rd_q};
    sum    = base + {err[DATA_W], err};
    ovf    = !((sum[DATA_W+1:DATA_W-1] == 3'b000) || (sum[DATA_W+1:DATA_W-1] == 3'b111));
    if (!ovf) begin
      result = sum[DATA_W-1:0];
    end else if (sum[DATA_W+1]) begin
      result = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      result = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      label_q <= '0;
      clear_q <= 1'b0;
      sat_q   <= 1'b0;
      fwd_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            label_q <= label;
            clear_q <= clear_acc;
            sat_q   <= 1'b0;
            idx_q   <= '0;
            state_q <= StRdFwd;
          end
        end
        StRdFwd: state_q <= StRdAcc;
        StRdAcc: begin
          fwd_q   <= eng_rd_q;
          state_q <= StRdAcc == StRdAcc ? StWrAcc : StIdle;
        end
        StWrAcc: begin
          if (ovf) begin
            sat_q <= 1'b1;
          end
          if (idx_q == ADDR_W'(NUM_CELL - 1)) begin
            state_q <= StDone;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= StRdFwd;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // RAM contents survive reset; reset only suppresses writes in its cycle.
  always_ff @(posedge clk) begin
    eng_rd_q <= mem[eng_addr];
    if (!reset) begin
      if (eng_we) begin
        mem[acc_addr] <= result;
      end else if (!busy && we) begin
        mem[addr] <= data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else if (!busy) begin
      q_q <= mem[addr];
    end
  end

endmodule

// File: tb/tb_error_accum_ram.sv
// Scoreboard bench for error_accum_ram: host reads and pass completions are
// queued as expectations and checked by a negedge monitor.
module tb_error_accum_ram;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [7:0]  addr = '0;
  logic [15:0] data = '0;
  logic [15:0] q;
  logic        start = 1'b0;
  logic [7:0]  label = '0;
  logic        clear_acc = 1'b0;
  logic        busy;
  logic        done;
  logic        sat;

  always #5 clk = ~clk;

  error_accum_ram dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .addr      (addr),
    .data      (data),
    .q         (q),
    .start     (start),
    .label     (label),
    .clear_acc (clear_acc),
    .busy      (busy),
    .done      (done),
    .sat       (sat)
  );

  typedef struct {
    string       nm;
    logic [15:0] v;
  } rd_exp_t;

  typedef struct {
    int   len;
    logic sat;
  } pass_exp_t;

  rd_exp_t   rd_q[$];
  pass_exp_t pass_q[$];
  rd_exp_t   rd_e;
  pass_exp_t pass_e;

  int   n_tests = 0;
  int   n_fail = 0;
  int   busy_cnt = 0;
  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) rd_vld <= rd_req;

  // Monitor: host read data one cycle after request; pass length/sat on done.
  always @(negedge clk) begin
    if (rd_vld) begin
      if (rd_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_unexpected: got %0h expected no read", q);
      end else begin
        rd_e = rd_q.pop_front();
        check(rd_e.nm, 32'(q), 32'(rd_e.v));
      end
    end
    if (reset) begin
      busy_cnt = 0;
    end else if (busy) begin
      busy_cnt++;
    end
    if (done) begin
      if (pass_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL done_unexpected: got done=1 expected no done");
      end else begin
        pass_e = pass_q.pop_front();
        check("pass_len", 32'(busy_cnt), 32'(pass_e.len));
        check("pass_sat", 32'(sat), 32'(pass_e.sat));
      end
      busy_cnt = 0;
    end
  end

  task automatic drive(input logic w, input int a, input int d, input logic st,
                       input int lb, input logic clr, input logic rr);
    @(posedge clk);
    #1;
    we        = w;
    addr      = 8'(a);
    data      = 16'(d);
    start     = st;
    label     = 8'(lb);
    clear_acc = clr;
    rd_req    = rr;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic wr(input int a, input int d);
    drive(1'b1, a, d, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic rd(input int a, input int e, input string nm);
    drive(1'b0, a, 0, 1'b0, 0, 1'b0, 1'b1);
    rd_q.push_back('{nm, 16'(e)});
  endtask

  task automatic go(input int lb, input logic clr, input logic exp_sat);
    pass_q.push_back('{30, exp_sat});
    drive(1'b0, 0, 0, 1'b1, lb, clr, 1'b0);
    idle();
    @(negedge clk);
    check("start_busy", 32'(busy), 32'd1);
    check("start_sat_clr", 32'(sat), 32'd0);
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sat", 32'(sat), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Basic pass: fwd[i]=100*i, acc=0, label 2.
    for (int i = 0; i < 10; i++) begin
      wr(i, 100 * i);
      wr(10 + i, 0);
    end
    wr(20, 16'h5A5A);
    go(2, 1'b0, 1'b0);
    wait_done();
    rd(12, 1336, "t1_acc2");
    rd(10, 0, "t1_acc0");
    rd(15, -500, "t1_acc5");
    rd(19, -900, "t1_acc9");
    rd(3, 300, "t1_fwd3");
    rd(20, 16'h5A5A, "t1_outside");

    // Accumulate again, then overwrite.
    go(2, 1'b0, 1'b0);
    wait_done();
    rd(12, 2672, "t2_acc2");
    rd(15, -1000, "t2_acc5");
    go(2, 1'b1, 1'b0);
    wait_done();
    rd(12, 1336, "t2_clr_acc2");
    rd(15, -500, "t2_clr_acc5");

    // Out-of-range label: no target anywhere.
    go(10, 1'b1, 1'b0);
    wait_done();
    rd(12, -200, "t3_acc2");
    rd(19, -900, "t3_acc9");
    rd(10, 0, "t3_acc0");

    // Positive clamp, then a clean pass, then a negative clamp.
    wr(10, 32000);
    wr(0, -1000);
    go(0, 1'b0, 1'b1);
    wait_done();
    rd(10, 32767, "t4_pos_clamp");
    rd(11, -200, "t4_acc1");
    go(0, 1'b1, 1'b0);
    wait_done();
    rd(10, 2536, "t4_noclamp_acc0");
    rd(13, -300, "t4_noclamp_acc3");
    wr(13, -32000);
    wr(3, 1000);
    go(0, 1'b0, 1'b1);
    wait_done();
    rd(13, -32768, "t4_neg_clamp");
    rd(10, 5072, "t4_acc0_sum");
    wr(3, 300);
    wr(0, 0);

    // Host write and a second start during a pass are ignored.
    go(10, 1'b1, 1'b0);
    repeat (6) idle();
    wr(10, 1234);
    drive(1'b0, 0, 0, 1'b1, 2, 1'b0, 1'b0);
    idle();
    wait_done();
    rd(10, 0, "t5_drop_wr");
    rd(12, -200, "t5_acc2");
    rd(15, -500, "t5_acc5");

    // Reset in cell 1: cell 0 written, cell 1 untouched, no done.
    drive(1'b0, 0, 0, 1'b1, 0, 1'b0, 1'b0);
    idle();
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("t6_busy_after_rst", 32'(busy), 32'd0);
    check("t6_done_after_rst", 32'(done), 32'd0);
    repeat (40) idle();
    rd(10, 1536, "t6_acc0");
    rd(11, -100, "t6_acc1");
    rd(0, 0, "t6_fwd0");
    rd(1, 100, "t6_fwd1");
    rd(9, 900, "t6_fwd9");
    repeat (3) idle();

    check("rd_queue_empty", 32'(rd_q.size()), 32'd0);
    check("pass_queue_empty", 32'(pass_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
